// File: rtl/program_loader_if.sv
// Loader bus: start/length control, program word stream, and the register,
// data-memory, instruction-memory and PC write ports driven toward the core.
interface program_loader_if #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int NREGS      = 32
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);
    localparam int RA = $clog2(NREGS);

    logic          start;
    logic [IA:0]   prog_len;

    // Handshake: a program word transfers on a rising edge where word_valid and
    // word_ready are both 1; the source holds word_in stable while word_valid is 1,
    // and word_ready does not depend on word_valid.
    logic [31:0]   word_in;
    logic          word_valid;
    logic          word_ready;

    logic          imem_we;
    logic [IA-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          dmem_we;
    logic [DA-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          reg_we;
    logic [RA-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic          pc_we;
    logic [31:0]   pc_wdata;

    logic          core_halt;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    dbg_state;

    modport master (
        input  start, prog_len, word_in, word_valid,
        output word_ready,
        output imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata,
        output reg_we, reg_addr, reg_wdata,
        output pc_we, pc_wdata,
        output core_halt, busy, done, error, dbg_state
    );

    modport slave (
        output start, prog_len, word_in, word_valid,
        input  word_ready,
        input  imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata,
        input  reg_we, reg_addr, reg_wdata,
        input  pc_we, pc_wdata,
        input  core_halt, busy, done, error, dbg_state
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader ahead of the mips core: clears registers, fills data memory with
// word i = i, streams the program into instruction memory, then writes PC=0 and releases.
module program_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int NREGS      = 32
) (
    input logic              clk,
    input logic              rst,
    program_loader_if.master bus
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);
    localparam int RA = $clog2(NREGS);
    localparam int MX = (IA > DA) ? ((IA > RA) ? IA : RA) : ((DA > RA) ? DA : RA);
    localparam int CW = MX + 1;

    localparam logic [IA:0]   LEN_MAX   = (IA+1)'(IMEM_DEPTH);
    localparam logic [CW-1:0] REG_LAST  = CW'(NREGS - 1);
    localparam logic [CW-1:0] DMEM_LAST = CW'(DMEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLR_REG   = 3'd1,
        S_INIT_DMEM = 3'd2,
        S_LOAD_IMEM = 3'd3,
        S_RELEASE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [IA:0]   len_q;
    logic          done_q, halt_q, error_q;
    logic          oversize, accept_start, take_word, word_last;

    assign oversize     = bus.prog_len > LEN_MAX;
    assign accept_start = (state == S_IDLE) && bus.start && !oversize;
    assign take_word    = (state == S_LOAD_IMEM) && bus.word_valid;
    assign word_last    = cnt == (CW'(len_q) - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (accept_start) state_nx = S_CLR_REG;
            S_CLR_REG:   if (cnt == REG_LAST) state_nx = S_INIT_DMEM;
            S_INIT_DMEM: if (cnt == DMEM_LAST) state_nx = (len_q == '0) ? S_RELEASE : S_LOAD_IMEM;
            S_LOAD_IMEM: if (take_word && word_last) state_nx = S_RELEASE;
            S_RELEASE:   state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Counter restarts on every state change, so each phase indexes from 0
    // and the last-entry compares fire before any overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            halt_q  <= 1'b1;
            error_q <= 1'b0;
        end else begin
            error_q <= (state == S_IDLE) && bus.start && oversize;
            if (state_nx != state)
                cnt <= '0;
            else if (state == S_CLR_REG || state == S_INIT_DMEM || take_word)
                cnt <= cnt + CW'(1);
            if (accept_start) begin
                len_q  <= bus.prog_len;
                done_q <= 1'b0;
                halt_q <= 1'b1;
            end else if (state == S_RELEASE) begin
                done_q <= 1'b1;
                halt_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.word_ready = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_addr   = '0;
        bus.reg_wdata  = '0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        bus.pc_we      = 1'b0;
        case (state)
            S_CLR_REG: begin
                bus.reg_we   = 1'b1;
                bus.reg_addr = cnt[RA-1:0];
            end
            S_INIT_DMEM: begin
                bus.dmem_we    = 1'b1;
                bus.dmem_addr  = cnt[DA-1:0];
                bus.dmem_wdata = 32'(cnt);
            end
            S_LOAD_IMEM: begin
                // Only the imem write follows the handshake inputs combinationally.
                bus.word_ready = 1'b1;
                bus.imem_we    = bus.word_valid;
                bus.imem_addr  = cnt[IA-1:0];
                bus.imem_wdata = bus.word_in;
            end
            S_RELEASE: bus.pc_we = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_wdata  = 32'd0;
    assign bus.core_halt = halt_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.busy      = state != S_IDLE;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized program streams with random handshake
// gaps, checked against a write-trace and cycle-count model of the boot sequence.
module tb_program_loader;
    localparam int IMEM_DEPTH = 1024;
    localparam int DMEM_DEPTH = 1024;
    localparam int NREGS      = 32;
    localparam int IA         = $clog2(IMEM_DEPTH);

    localparam int K_REG  = 1;
    localparam int K_DMEM = 2;
    localparam int K_IMEM = 3;
    localparam int K_PC   = 4;

    logic clk = 1'b0;
    logic rst;

    program_loader_if #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .NREGS(NREGS)) bus ();

    program_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int kind, input int addr, input logic [31:0] data);
        return {4'(kind), 12'd0, 16'(addr), data};
    endfunction

    function automatic logic [8:0] ctl_vec();
        return {bus.core_halt, bus.busy, bus.done, bus.error, bus.word_ready,
                bus.reg_we, bus.dmem_we, bus.imem_we, bus.pc_we};
    endfunction

    // One full boot sequence; gaps[i] idle cycles precede word i once loading begins.
    task automatic run_seq(input int len, input int gap_lo, input int gap_hi,
                           input int ign_cyc, input string name);
        logic [31:0] words[$];
        int gaps[$];
        int load_cyc = 0;
        int cyc = 0, idx = 0, gap_left = 0, nwe, budget, first_bad = -1;
        int first_reg = -1, pc_cyc = -1, halt_fall = -1, done_rise = -1;
        int ready_cnt = 0, busy_cnt = 0, excl_bad = 0, exp_pc;
        logic halt_c1 = 1'b0;
        logic [2:0] post_vec = 3'b000;

        for (int i = 0; i < len; i++) begin
            words.push_back($urandom);
            gaps.push_back(int'($urandom_range(gap_hi, gap_lo)));
            load_cyc += gaps[i] + 1;
        end
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < NREGS; i++)      exp_q.push_back(ev(K_REG, i, 32'd0));
        for (int i = 0; i < DMEM_DEPTH; i++) exp_q.push_back(ev(K_DMEM, i, 32'(i)));
        for (int i = 0; i < len; i++)        exp_q.push_back(ev(K_IMEM, i, words[i]));
        exp_q.push_back(ev(K_PC, 0, 32'd0));
        exp_pc = 1 + NREGS + DMEM_DEPTH + load_cyc;

        if (len > 0) gap_left = gaps[0];
        budget = NREGS + DMEM_DEPTH + load_cyc + 40;
        while (cyc < budget && !(done_rise >= 0 && cyc > done_rise + 1)) begin
            @(negedge clk);
            bus.start      = (cyc == 0) || (cyc == ign_cyc);
            bus.prog_len   = (cyc == ign_cyc) ? (IA+1)'(9) : (IA+1)'(len);
            bus.word_valid = 1'b0;
            if (bus.word_ready && idx < len) begin
                if (gap_left > 0) gap_left--;
                else begin
                    bus.word_valid = 1'b1;
                    bus.word_in    = words[idx];
                end
            end
            #1;
            nwe = int'(bus.reg_we) + int'(bus.dmem_we) + int'(bus.imem_we) + int'(bus.pc_we);
            if (nwe > 1) excl_bad++;
            if (bus.reg_we) begin
                act_q.push_back(ev(K_REG, int'(bus.reg_addr), bus.reg_wdata));
                if (first_reg < 0) first_reg = cyc;
            end
            if (bus.dmem_we) act_q.push_back(ev(K_DMEM, int'(bus.dmem_addr), bus.dmem_wdata));
            if (bus.imem_we) act_q.push_back(ev(K_IMEM, int'(bus.imem_addr), bus.imem_wdata));
            if (bus.pc_we) begin
                act_q.push_back(ev(K_PC, 0, bus.pc_wdata));
                if (pc_cyc < 0) pc_cyc = cyc;
            end
            if (bus.word_ready) ready_cnt++;
            if (bus.busy) busy_cnt++;
            if (cyc == 1) halt_c1 = bus.core_halt;
            if (cyc > 0 && halt_fall < 0 && !bus.core_halt) halt_fall = cyc;
            if (done_rise >= 0 && cyc == done_rise + 1) post_vec = {bus.done, bus.core_halt, bus.busy};
            if (cyc > 0 && done_rise < 0 && bus.done) done_rise = cyc;
            if (bus.word_valid && bus.word_ready) begin
                idx++;
                gap_left = (idx < len) ? gaps[idx] : 0;
            end
            cyc++;
        end
        bus.start      = 1'b0;
        bus.word_valid = 1'b0;
        bus.prog_len   = '0;

        check({name, ":trace_len"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            if (act_q[i] !== exp_q[i]) begin
                first_bad = i;
                $display("  %s first differing write #%0d: got 0x%0h expected 0x%0h",
                         name, i, act_q[i], exp_q[i]);
                break;
            end
        end
        check({name, ":trace_first_diff"}, 64'(first_bad), 64'(-1));
        check({name, ":first_reg_cycle"}, 64'(first_reg), 64'(1));
        check({name, ":halt_reasserted"}, 64'(halt_c1), 64'(1));
        check({name, ":pc_we_cycle"}, 64'(pc_cyc), 64'(exp_pc));
        check({name, ":halt_fall_cycle"}, 64'(halt_fall), 64'(exp_pc + 1));
        check({name, ":done_rise_cycle"}, 64'(done_rise), 64'(exp_pc + 1));
        check({name, ":ready_cycles"}, 64'(ready_cnt), 64'(load_cyc));
        check({name, ":busy_cycles"}, 64'(busy_cnt), 64'(NREGS + DMEM_DEPTH + load_cyc + 2));
        check({name, ":we_exclusive"}, 64'(excl_bad), 64'(0));
        check({name, ":idle_after_done"}, 64'(post_vec), 64'(3'b100));
    endtask

    task automatic run_oversize();
        int err_cnt = 0, err_cyc = -1, busy_seen = 0, we_seen = 0;
        check("oversize:prior_done_halt", 64'({bus.done, bus.core_halt}), 64'(2'b10));
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            bus.start    = (cyc == 0);
            bus.prog_len = (IA+1)'(IMEM_DEPTH + 1);
            #1;
            if (bus.error) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (bus.busy) busy_seen++;
            if (bus.reg_we || bus.dmem_we || bus.imem_we || bus.pc_we) we_seen++;
        end
        bus.start    = 1'b0;
        bus.prog_len = '0;
        check("oversize:error_pulses", 64'(err_cnt), 64'(1));
        check("oversize:error_cycle", 64'(err_cyc), 64'(1));
        check("oversize:busy", 64'(busy_seen), 64'(0));
        check("oversize:writes", 64'(we_seen), 64'(0));
        check("oversize:done_halt_kept", 64'({bus.done, bus.core_halt}), 64'(2'b10));
    endtask

    task automatic run_reset_mid();
        int cyc = 0;
        logic hit = 1'b0;
        while (cyc < 700 && !hit) begin
            @(negedge clk);
            bus.start    = (cyc == 0);
            bus.prog_len = (IA+1)'(5);
            #1;
            if (bus.dmem_we && int'(bus.dmem_addr) == 500) hit = 1'b1;
            cyc++;
        end
        check("rst_mid:reached_dmem_500", 64'(hit), 64'(1));
        check("rst_mid:dmem_500_cycle", 64'(cyc - 1), 64'(1 + NREGS + 500));
        rst = 1'b1;
        #1;
        check("rst_mid:ctl", 64'(ctl_vec()), 64'(9'h100));
        check("rst_mid:addrs", 64'({bus.reg_addr, bus.dmem_addr, bus.imem_addr}), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.prog_len   = '0;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset:ctl", 64'(ctl_vec()), 64'(9'h100));
        check("reset:idle_state", 64'(bus.dbg_state), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset:ctl", 64'(ctl_vec()), 64'(9'h100));

        run_seq(4, 0, 0, -1, "full_load");
        run_oversize();
        run_seq(2, 0, 0, -1, "after_oversize");
        run_seq(3, 5, 5, -1, "stall");
        run_seq(0, 0, 0, -1, "zero_len");
        run_seq(6, 0, 1, 5, "ignored_start");
        run_reset_mid();
        run_seq(3, 0, 2, -1, "restart");
        run_seq(IMEM_DEPTH, 0, 0, -1, "full_depth");
        for (int r = 0; r < 3; r++)
            run_seq(int'($urandom_range(12, 1)), 0, 3, -1, $sformatf("rand%0d", r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
